mpu_frame_assembler: RTL
========================

Name: mpu_frame_assembler

Overview:
- Downstream consumer of the I2C read sequencer's burst read of MPU-6050 registers 0x3B..0x48 (14 bytes).
- Collects the byte stream into seven signed 16-bit words: accl x/y/z, temp, gyro x/y/z.
- Publishes each complete frame with a one-cycle valid pulse.
- Drives the 8-LED thermometer display from the absolute value of a selectable axis.

Parameters:
- FRAME_BYTES, 14, bytes per frame; fixed at 14 (7 words, high byte first).
- AVG_SHIFT, 2, IIR smoothing shift; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- frame_start  input  1  pulse: a new burst read begins (repeated-start with R_Wbar=1 acknowledged).
- byte_valid  input  1  pulse: byte_data holds the next received byte.
- byte_data  input  8  received byte.
- axis_sel  input  3  display source: 0=ax, 1=ay, 2=az, 3=temp, 4=gx, 5=gy, 6=gz; 7 is treated as 2.
- accl_x, accl_y, accl_z  output  16 each  latest published accelerometer words (two's complement).
- temp  output  16  latest published temperature word.
- gyro_x, gyro_y, gyro_z  output  16 each  latest published gyroscope words.
- sample_valid  output  1  one-cycle pulse when all seven words update.
- frame_error  output  1  one-cycle pulse on a short or overlong frame.
- display  output  8  thermometer bar of |selected word|.

Behaviour:
- Reset: all word outputs 0, sample_valid 0, frame_error 0, display 8'h00, byte_count 0, state COLLECT. Reset mid-frame discards partial data.
- States: COLLECT, PUBLISH.
- COLLECT:
  - byte_valid writes byte_data into staging slot byte_count, then byte_count increments.
  - Even index = high byte, odd index = low byte of word index/2.
  - When byte 13 is accepted, byte_count returns to 0 and the next state is PUBLISH.
- PUBLISH (exactly one cycle):
  - Staging words are copied to the output registers and sample_valid=1 in the same cycle.
  - The next state is COLLECT.
  - A byte_valid arriving in PUBLISH is accepted as byte 0 of the next frame. No byte is ever dropped.
- Latency: sample_valid asserts 1 clk after the clk in which byte 13 was accepted. The outputs are valid in that same clk and hold until the next publish.
- frame_start:
  - In COLLECT with byte_count != 0: pulse frame_error next clk, clear byte_count, discard staging. Outputs are unchanged.
  - With byte_count == 0: no effect.
  - frame_start and byte_valid in the same clk: the restart applies first, and the byte is stored as byte 0 (byte_count becomes 1).
- Overlong frame: not possible by construction. A 15th byte starts a new frame. The sequencer always ends with NACK, so no error is generated for it.
- Display:
  - Updates only in the cycle after sample_valid, or in the cycle after axis_sel changes. It uses the published (or filtered) value.
  - abs = (w[15]) ? -w : w. 16'h8000 saturates to 16'h7FFF.
  - n = abs[14:12]; display = (1 << (n+1)) - 1. So 0 gives 8'h01 and 7 gives 8'hFF.
- Width rules: all arithmetic is 16-bit two's complement. The negate is computed in 17 bits, then saturated.
- sample_valid and frame_error never assert in the same clk. A restart in PUBLISH only affects the next frame.

Optional Feature:
- Macro MPU_FRAME_IIR_EN.
- When defined: each published word is y <= y + ((x - y) >>> AVG_SHIFT).
  - Arithmetic shift, 17-bit intermediate.
  - The first frame after reset loads y = x directly.
  - sample_valid timing is unchanged; the outputs carry filtered values.
- When undefined: the outputs carry raw words, and the filter registers are absent.

Test Plan:
- Reset, then 14 bytes 00 10 00 20 40 00 01 00 FF F0 00 05 80 00 → next clk: sample_valid=1, accl_x=0x0010, accl_y=0x0020, accl_z=0x4000, temp=0x0100, gyro_x=0xFFF0, gyro_y=0x0005, gyro_z=0x8000. With axis_sel=2, display=8'h1F.
- Same frame with axis_sel=6 → display=8'hFF (saturated 0x8000). Set axis_sel=4 → display=8'h01.
- 5 bytes, then frame_start, then a full 14-byte frame → frame_error pulses once. The outputs reflect only the second frame, and a single sample_valid pulse occurs.
- Back-to-back frames with byte_valid high on every clk, including the PUBLISH clk → two sample_valid pulses 14 clks apart. The second frame is intact.
- Assert reset after byte 7 of a frame → outputs 0 and display 8'h00. A following full frame publishes correctly.
- MPU_FRAME_IIR_EN with AVG_SHIFT=2: accl_z frames 0x4000, then 0x0000 → published 0x4000, then 0x3000.

Source files
------------

// File: rtl/mpu_frame_assembler_if.sv
// Byte-stream link between the I2C read sequencer and the frame assembler.
//
// Signals:
//   frame_start  pulse: a new burst read of the sensor registers begins
//   byte_valid   pulse: byte_data carries the next received byte
//   byte_data    received byte
//
// Modports:
//   master  driven by the read sequencer (byte source)
//   slave   consumed by mpu_frame_assembler
interface mpu_frame_assembler_if;
  logic       frame_start;
  logic       byte_valid;
  logic [7:0] byte_data;

  modport master (output frame_start, output byte_valid, output byte_data);
  modport slave  (input  frame_start, input  byte_valid, input  byte_data);
endinterface

// File: rtl/mpu_frame_assembler.sv
// MPU-6050 frame assembler.
//
// Collects the 14-byte burst read of registers 0x3B..0x48 into seven signed
// 16-bit words (high byte first), publishes each complete frame with a
// one-cycle sample_valid pulse, and drives an 8-LED thermometer bar from the
// magnitude of a selectable word.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   stream        byte stream from the read sequencer (slave modport)
//   axis_sel      display source: 0=ax 1=ay 2=az 3=temp 4=gx 5=gy 6=gz 7=az
//   accl_x/y/z    latest published accelerometer words
//   temp          latest published temperature word
//   gyro_x/y/z    latest published gyroscope words
//   sample_valid  one-cycle pulse while a freshly published frame is shown
//   frame_error   one-cycle pulse after a frame was restarted mid-way
//   display       thermometer bar of |selected word|
//
// Optional feature:
//   MPU_FRAME_IIR_EN  when defined, each published word is smoothed with
//                     y <= y + ((x - y) >>> AVG_SHIFT); the first frame after
//                     reset loads the raw value.
module mpu_frame_assembler #(
  parameter int FRAME_BYTES = 14
`ifdef MPU_FRAME_IIR_EN
  ,
  parameter int AVG_SHIFT = 2
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  mpu_frame_assembler_if.slave  stream,
  input  logic [2:0]            axis_sel,
  output logic [15:0]           accl_x,
  output logic [15:0]           accl_y,
  output logic [15:0]           accl_z,
  output logic [15:0]           temp,
  output logic [15:0]           gyro_x,
  output logic [15:0]           gyro_y,
  output logic [15:0]           gyro_z,
  output logic                  sample_valid,
  output logic                  frame_error,
  output logic [7:0]            display
);

  localparam int         WORDS      = FRAME_BYTES / 2;
  localparam logic [3:0] LAST_INDEX = 4'(FRAME_BYTES - 1);

  typedef enum logic {COLLECT, PUBLISH} state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  byte_count;
  logic [3:0]  count_next;
  logic [3:0]  write_index;
  logic        restart;
  logic        last_byte;

  logic [15:0] stage      [WORDS];
  logic [15:0] frame_word [WORDS];
  logic [15:0] word_q     [WORDS];

  logic [2:0]  axis_q;
  logic [15:0] selected;
  logic [16:0] mag_wide;
  logic [15:0] mag;
  logic [7:0]  bar;

  // Complete frame as it stands at the moment the last byte arrives: the
  // final low byte bypasses staging so the outputs can load on that same edge.
  always_comb begin
    for (int i = 0; i < WORDS; i++) begin
      frame_word[i] = stage[i];
    end
    frame_word[WORDS-1][7:0] = stream.byte_data;
  end

  // Next-state logic. A restart clears the count before the same-cycle byte
  // is placed, so that byte lands in slot 0. PUBLISH always lasts one cycle
  // and still accepts a byte (byte_count is already 0 there).
  always_comb begin
    state_next   = state;
    count_next   = byte_count;
    write_index  = byte_count;
    restart      = 1'b0;
    last_byte    = 1'b0;
    sample_valid = 1'b0;

    if (state == PUBLISH) begin
      sample_valid = 1'b1;
      state_next   = COLLECT;
    end else if (stream.frame_start && (byte_count != 4'd0)) begin
      restart     = 1'b1;
      write_index = 4'd0;
      count_next  = 4'd0;
    end

    if (stream.byte_valid) begin
      if (write_index == LAST_INDEX) begin
        last_byte  = 1'b1;
        count_next = 4'd0;
        state_next = PUBLISH;
      end else begin
        count_next = write_index + 4'd1;
      end
    end
  end

  // State, byte counter and the registered restart error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= COLLECT;
      byte_count  <= 4'd0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_next;
      byte_count  <= count_next;
      frame_error <= restart;
    end
  end

  // Staging buffer: even index is the high byte, odd index the low byte.
  // It needs no reset because every slot is rewritten before a publish.
  always_ff @(posedge clk) begin
    if (stream.byte_valid) begin
      if (write_index[0]) begin
        stage[write_index[3:1]][7:0] <= stream.byte_data;
      end else begin
        stage[write_index[3:1]][15:8] <= stream.byte_data;
      end
    end
  end

`ifdef MPU_FRAME_IIR_EN
  logic               primed;
  logic signed [16:0] diff     [WORDS];
  logic        [15:0] filtered [WORDS];

  // 17-bit difference so x - y cannot overflow before the arithmetic shift.
  always_comb begin
    for (int i = 0; i < WORDS; i++) begin
      diff[i]     = $signed({frame_word[i][15], frame_word[i]}) -
                    $signed({word_q[i][15], word_q[i]});
      filtered[i] = 16'(word_q[i] + 16'(diff[i] >>> AVG_SHIFT));
    end
  end

  // Filter state doubles as the published word registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      primed <= 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        word_q[i] <= 16'h0000;
      end
    end else if (last_byte) begin
      primed <= 1'b1;
      for (int i = 0; i < WORDS; i++) begin
        word_q[i] <= primed ? filtered[i] : frame_word[i];
      end
    end
  end
`else
  // Published word registers load raw words on the last-byte edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) begin
        word_q[i] <= 16'h0000;
      end
    end else if (last_byte) begin
      for (int i = 0; i < WORDS; i++) begin
        word_q[i] <= frame_word[i];
      end
    end
  end
`endif

  assign accl_x = word_q[0];
  assign accl_y = word_q[1];
  assign accl_z = word_q[2];
  assign temp   = word_q[3];
  assign gyro_x = word_q[4];
  assign gyro_y = word_q[5];
  assign gyro_z = word_q[6];

  // Magnitude of the selected word. 0x8000 negates to 0x08000 in 17 bits,
  // which the saturation clamps to 0x7FFF. Bar segment k lights once the
  // magnitude reaches k * 0x1000; segment 0 is always lit.
  always_comb begin
    case (axis_sel)
      3'd0:    selected = word_q[0];
      3'd1:    selected = word_q[1];
      3'd3:    selected = word_q[3];
      3'd4:    selected = word_q[4];
      3'd5:    selected = word_q[5];
      3'd6:    selected = word_q[6];
      default: selected = word_q[2];
    endcase
    mag_wide = selected[15] ? (17'd0 - {selected[15], selected})
                            : {selected[15], selected};
    mag = (|mag_wide[16:15]) ? 16'h7FFF : mag_wide[15:0];
    bar = 8'h01;
    for (int k = 1; k < 8; k++) begin
      bar[k] = (mag >= 16'(k << 12));
    end
  end

  // The bar refreshes only after a publish or after axis_sel moves, so it
  // stays dark from reset until one of those happens.
  always_ff @(posedge clk) begin
    if (reset) begin
      display <= 8'h00;
      axis_q  <= axis_sel;
    end else begin
      axis_q <= axis_sel;
      if ((state == PUBLISH) || (axis_sel != axis_q)) begin
        display <= bar;
      end
    end
  end

endmodule
